heat_channel_scheduler: RTL
===========================

# heat_channel_scheduler

Round-robin scheduler that shares one moving-average/threshold datapath among NUM_CH temperature sensor channels in the Heatwatch design. It accepts 11-bit samples from sensor front-ends over a req/ack handshake. For each sample it updates that channel's WINDOW-deep sliding sum, then publishes the channel's average. It maintains a per-channel over-temperature alarm with hysteresis. It sits between the sensor sampling logic and the alarm/display logic.

## Interface
- NUM_CH, 4, number of sensor channels (2..8)
- DATA_W, 11, sample and average width
- WINDOW, 4, samples per average; power of two (2..16)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- ch_req  in  NUM_CH  per-channel sample request; held high with data stable until ack
- ch_data  in  NUM_CH*DATA_W  channel k sample at bits [k*DATA_W +: DATA_W], unsigned
- ch_ack  out  NUM_CH  one-cycle grant/consume pulse, one-hot or zero
- thr_high  in  DATA_W  alarm set threshold, unsigned
- thr_low  in  DATA_W  alarm clear threshold, unsigned; thr_low <= thr_high
- flush  in  1  synchronous clear of windows, fill counts, alarms, RR pointer
- avg_out  out  DATA_W  latest published average
- avg_ch  out  clog2(NUM_CH)  channel of avg_out
- avg_valid  out  1  one-cycle pulse when avg_out/avg_ch update
- alarm  out  NUM_CH  per-channel over-temperature flag
- busy  out  1  high when state is not IDLE

## Operation
- FSM states: IDLE, ACCUM, CHECK.
  - IDLE: if any ch_req, the round-robin winner is chosen. Its index and data are latched, ch_ack[winner] pulses, and the FSM goes to ACCUM. Otherwise it stays in IDLE.
  - ACCUM: sum[ch] <= sum[ch] - buf[ch][wptr[ch]] + sample. Then buf[ch][wptr[ch]] <= sample. wptr wraps at WINDOW. fill[ch] increments, saturating at WINDOW. Next state CHECK.
  - CHECK: avg = sum[ch] >> log2(WINDOW), truncated. avg_out, avg_ch and avg_valid are registered. Next state IDLE.
- Alarm is evaluated in CHECK only when fill[ch] == WINDOW. Other channels' alarms are untouched.
  - avg > thr_high sets the alarm.
  - avg < thr_low clears it.
  - Otherwise it holds. Equality never changes state.
- Before the window is full, averages are still published. Missing buffer entries count as 0.
- Sum width is DATA_W + log2(WINDOW); it never overflows. avg always fits DATA_W.
- Round robin:
  - Pointer rr starts at 0.
  - Search order is rr, rr+1, ..., wrapping modulo NUM_CH.
  - After a grant to channel k, rr <= (k+1) mod NUM_CH.
- flush, sampled high in any state:
  - Next state is IDLE.
  - sum, buf, wptr, fill, alarm and rr are cleared.
  - avg_out and avg_ch are held.
  - avg_valid is 0 next cycle.
  - A sample in flight is discarded; its ack has already been given.
  - flush has priority over a same-cycle grant, so no ack is issued.
- Reset values (reset low): state IDLE, ch_ack 0, avg_out 0, avg_ch 0, avg_valid 0, alarm 0, busy 0. All sums, buffers, pointers and fill counts are 0, and rr is 0.

## Timing
- Request seen in IDLE at edge t:
  - ch_ack high in cycle t+1 (registered).
  - ACCUM in t+1, CHECK in t+2.
  - avg_valid high in cycle t+3, with alarm updated in the same cycle.
  - IDLE again in t+3.
- Throughput: one sample per 3 cycles. Latency from grant to avg_valid is 3 cycles.
- A requester must drop ch_req, or present a new sample, by the cycle after it sees ch_ack. Otherwise req still high at the next IDLE is treated as a new sample.
- Requests arriving during ACCUM/CHECK wait. They are arbitrated in the next IDLE cycle, which is t+3 and overlaps avg_valid.
- thr_high and thr_low are sampled in CHECK. They may change at any time.

## Test plan
- Reset: assert reset low mid-ACCUM with alarm[1]=1 -> all outputs 0 immediately, no ack or avg_valid after release until a new req.
- Hysteresis, ch0 (WINDOW=4, thr_high=100, thr_low=90):
  - Samples 100, 104, 108, 112 -> avg 25, 51, 78, 106. alarm[0] rises only with the fourth avg_valid.
  - Next sample 60 -> avg 96, alarm held at 1.
  - Next sample 40 -> avg 80, alarm[0] cleared.
- Round robin: ch0, ch1 and ch2 all request at once -> acks 0, 1, 2 at 3-cycle spacing, avg_ch 0, 1, 2. Then ch0 and ch2 request -> grant order 0, then 2.
- Boundary: four samples of 2047 on ch3 -> avg 2047, no overflow. Alarm sets if thr_high=2046. With avg == thr_high=2047, alarm stays 0.
- flush: flush during CHECK -> no avg_valid that cycle, alarms 0, fill cleared. A following single sample of 80 -> avg 20.
- Isolation: alarm[0]=1, then a ch1 window of low samples -> alarm[0] unchanged.

Source files
------------

// File: rtl/heat_channel_scheduler_if.sv
// Bundle of every non-clock/non-reset signal of the heat channel scheduler.
//
// Handshake (sensor side): a front-end raises ch_req[k] with ch_data slot k
// stable and keeps both unchanged until it sees ch_ack[k]. ch_ack is a
// single-cycle pulse that both grants and consumes the sample, and at most one
// bit is set per cycle. The requester drops ch_req[k], or presents the next
// sample, no later than the cycle after the ack. A request still high at the
// next arbitration point counts as a new sample.
//
// Result side: avg_valid pulses for one cycle whenever avg_out/avg_ch change.
// alarm holds a level per channel. busy is high while a sample is processed.
// fsm_state exposes the scheduler state: 0 idle, 1 accumulate, 2 check.
//
// Modports: master = sensor/host side (bench), slave = scheduler.
interface heat_channel_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 11
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ack;
  logic [DATA_W-1:0]        thr_high;
  logic [DATA_W-1:0]        thr_low;
  logic                     flush;
  logic [DATA_W-1:0]        avg_out;
  logic [CH_W-1:0]          avg_ch;
  logic                     avg_valid;
  logic [NUM_CH-1:0]        alarm;
  logic                     busy;
  logic [1:0]               fsm_state;

  modport master (
    output ch_req, ch_data, thr_high, thr_low, flush,
    input  ch_ack, avg_out, avg_ch, avg_valid, alarm, busy, fsm_state
  );

  modport slave (
    input  ch_req, ch_data, thr_high, thr_low, flush,
    output ch_ack, avg_out, avg_ch, avg_valid, alarm, busy, fsm_state
  );
endinterface

// File: rtl/heat_channel_scheduler.sv
// Round-robin scheduler that shares one moving-average/threshold datapath
// among NUM_CH temperature channels.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low; clears all state
//   bus    - heat_channel_scheduler_if.slave: per-channel req/data/ack,
//            thresholds, flush, published average/channel/valid, alarms,
//            busy and fsm_state
//
// Each granted sample takes three cycles: IDLE (grant), ACCUM (update the
// sliding sum and window buffer), CHECK (publish average, update alarm).
module heat_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 11,
  parameter int WINDOW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  heat_channel_scheduler_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LOG_W = $clog2(WINDOW);
  localparam int SUM_W = DATA_W + LOG_W;
  localparam logic [LOG_W:0] FULL = (LOG_W+1)'(WINDOW);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]        state;
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   cur_ch;
  logic [DATA_W-1:0] cur_data;
  logic [SUM_W-1:0]  sum     [NUM_CH];
  logic [DATA_W-1:0] win_buf [NUM_CH][WINDOW];
  logic [LOG_W-1:0]  wptr    [NUM_CH];
  logic [LOG_W:0]    fill    [NUM_CH];
  logic [NUM_CH-1:0] alarm_q;
  logic [NUM_CH-1:0] ack_q;
  logic [DATA_W-1:0] avg_q;
  logic [CH_W-1:0]   avg_ch_q;
  logic              avg_valid_q;

  logic              found;
  logic [CH_W-1:0]   winner;
  logic [CH_W-1:0]   rr_next;
  logic [SUM_W-1:0]  next_sum;
  logic [DATA_W-1:0] cur_avg;

  // First requester at or after rr, wrapping modulo NUM_CH.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && bus.ch_req[(int'(rr) + i) % NUM_CH]) begin
        found  = 1'b1;
        winner = CH_W'((int'(rr) + i) % NUM_CH);
      end
    end
  end

  assign rr_next = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

  // Sliding sum: drop the sample being overwritten, add the new one. Unwritten
  // slots are zero, so a partially filled window still averages correctly
  // with the missing entries counting as 0.
  assign next_sum = sum[cur_ch] - SUM_W'(win_buf[cur_ch][wptr[cur_ch]])
                  + SUM_W'(cur_data);
  assign cur_avg  = DATA_W'(sum[cur_ch] >> LOG_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr          <= '0;
      cur_ch      <= '0;
      cur_data    <= '0;
      alarm_q     <= '0;
      ack_q       <= '0;
      avg_q       <= '0;
      avg_ch_q    <= '0;
      avg_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c]  <= '0;
        wptr[c] <= '0;
        fill[c] <= '0;
        for (int w = 0; w < WINDOW; w++) win_buf[c][w] <= '0;
      end
    end else begin
      ack_q       <= '0;
      avg_valid_q <= 1'b0;
      if (bus.flush) begin
        // Flush wins over any grant this cycle; published average is kept.
        state   <= IDLE;
        rr      <= '0;
        alarm_q <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          sum[c]  <= '0;
          wptr[c] <= '0;
          fill[c] <= '0;
          for (int w = 0; w < WINDOW; w++) win_buf[c][w] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              ack_q[winner] <= 1'b1;
              cur_ch        <= winner;
              cur_data      <= bus.ch_data[int'(winner)*DATA_W +: DATA_W];
              rr            <= rr_next;
              state         <= ACCUM;
            end
          end
          ACCUM: begin
            sum[cur_ch]                   <= next_sum;
            win_buf[cur_ch][wptr[cur_ch]] <= cur_data;
            wptr[cur_ch]                  <= wptr[cur_ch] + 1'b1;
            if (fill[cur_ch] != FULL) fill[cur_ch] <= fill[cur_ch] + 1'b1;
            state <= CHECK;
          end
          CHECK: begin
            avg_q       <= cur_avg;
            avg_ch_q    <= cur_ch;
            avg_valid_q <= 1'b1;
            // Hysteresis: only strict crossings move the alarm, and only
            // once the window holds WINDOW real samples.
            if (fill[cur_ch] == FULL) begin
              if (cur_avg > bus.thr_high)     alarm_q[cur_ch] <= 1'b1;
              else if (cur_avg < bus.thr_low) alarm_q[cur_ch] <= 1'b0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ch_ack    = ack_q;
  assign bus.avg_out   = avg_q;
  assign bus.avg_ch    = avg_ch_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.alarm     = alarm_q;
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;
endmodule
